arbiter_rr_hold: RTL and testbench
==================================

Name: arbiter_rr_hold

Overview:
- Parametrised N-input round-robin arbiter with grant hold, for router output-port allocation.
- Generalises the fixed 5-input, fixed-priority, hold-while-requested arbiter:
  - port count is a parameter;
  - priority rotates after every grant, so no input starves;
  - direct hand-over between requesters with no idle bubble;
  - optional maximum-hold timeout that forces re-arbitration when other ports are waiting.
- One instance per router output port; the grant drives the crossbar select and the input-buffer read enables.

Parameters:
- N, 5, number of requesting inputs (2..16).
- ID_W, 3, width of grant index output; must satisfy 2^ID_W >= N.
- MAX_HOLD, 0, maximum consecutive cycles one input may hold the grant while others request; 0 disables the timeout.
- CNT_W, 8, width of hold counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  N  request vector, bit i = input i requests the output.
- gnt  out  N  registered one-hot grant, all-zero when no owner.
- gnt_valid  out  1  registered, high when gnt is non-zero.
- gnt_id  out  ID_W  registered binary index of the granted input, 0 when gnt_valid is low.

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, ptr=0, hold_cnt=0.
  - rst has priority over every other event, including mid-grant.
- ptr is the highest-priority index. Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- Every new grant to input k sets ptr=(k+1) mod N on the same edge.
- Latency: one cycle. Outputs reflect the decision made from req sampled at the previous edge; there is no combinational path from req to gnt.
- States:
  - IDLE: gnt=0.
    - If req != 0, grant the first requester in search order and go to GRANT.
    - Otherwise stay in IDLE.
  - GRANT: owner index o.
    - Owner still requesting, no timeout: hold the grant and increment hold_cnt.
    - Owner drops req and (req without bit o) != 0: hand over directly to the first other requester in search order, stay in GRANT, hold_cnt=0. No idle cycle.
    - Owner drops req and no other request: go to IDLE, gnt=0.
- Timeout, only when MAX_HOLD != 0:
  - When hold_cnt == MAX_HOLD-1, req[o] is high and another input requests, re-arbitrate on this edge. The grant moves to the first other requester in search order, even though req[o] is still high.
  - If no other input requests, the owner keeps the grant and hold_cnt saturates at MAX_HOLD-1.
  - MAX_HOLD=1 means re-arbitrate every cycle under contention.
- hold_cnt:
  - Cleared on every new grant and in IDLE.
  - Increments by 1 per cycle while the same owner is held.
  - Never wraps: it saturates at 2^CNT_W-1 when MAX_HOLD=0.
- A former owner re-requesting competes normally. Because ptr has moved past it, it has lowest priority.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == (gnt != 0).
  - gnt_id always matches gnt.
  - gnt[i]=1 only if req[i] was high at the deciding edge.
- Requests on bits at or above N do not exist. Unused ID_W codes are never produced.

Test Plan:
- Reset then req=5'b10110 → cycle+1: gnt=5'b00010, gnt_id=1, ptr=2. Hold req → gnt unchanged for 20 cycles (MAX_HOLD=0).
- Owner drops, others pending: from gnt=00010 with req changing to 5'b10100 → next cycle gnt=5'b00100, gnt_id=2, no zero cycle. Then req=0 → gnt=0, gnt_valid=0 next cycle.
- Round-robin fairness: all 5 inputs request continuously, each requester drops its req for one cycle after it is granted (one-cycle packets) → grant order 0,1,2,3,4,0.
- Timeout, MAX_HOLD=4, req=5'b00011 held constant: input 0 granted for 4 cycles, then input 1 for 4 cycles, alternating. With req=5'b00001 only, input 0 holds indefinitely and hold_cnt stays at 3.
- Reset mid-grant: while gnt=5'b01000, assert rst for one cycle with req=5'b11111 → gnt=0 after the reset edge. The first grant after rst deasserts goes to input 0 (ptr=0).
- N=2, ID_W=1 and N=16, ID_W=4 builds: random req for 10k cycles, checking:
  - one-hot invariant;
  - gnt_id consistency;
  - no requester waits more than (N-1)*MAX_HOLD+N cycles, with MAX_HOLD=8.

Source files
------------

// File: rtl/arbiter_rr_hold.sv
// rtl/arbiter_rr_hold.sv - N-input round-robin arbiter with grant hold and optional hold timeout
// One instance per router output port; gnt drives crossbar select and input-buffer read enables.
module arbiter_rr_hold #(
   parameter int N        = 5,
   parameter int ID_W     = 3,
   parameter int MAX_HOLD = 0,
   parameter int CNT_W    = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   output logic            gnt_valid,
   output logic [ID_W-1:0] gnt_id
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

   state_t          state, state_nxt;
   logic [ID_W-1:0] owner, owner_nxt;
   logic [ID_W-1:0] ptr, ptr_nxt;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
   logic [N-1:0]    gnt_nxt;
   logic [ID_W-1:0] gnt_id_nxt;

   logic [N-1:0]    own_mask;
   logic [N-1:0]    others;
   logic            owner_req;
   logic            at_limit;
   logic            timeout;
   logic            pick_found;
   logic [ID_W-1:0] pick_idx;

   // First set bit of r at or after p, wrapping; returns {found, index}.
   function automatic logic [ID_W:0] pick(input logic [N-1:0] r, input logic [ID_W-1:0] p);
      logic            found;
      logic [ID_W-1:0] idx;
      int              best_d;
      int              d;
      found  = 1'b0;
      idx    = '0;
      best_d = N;
      for (int i = 0; i < N; i++) begin
         d = i - int'(p);
         if (d < 0) d = d + N;
         if (r[i] && d < best_d) begin
            best_d = d;
            found  = 1'b1;
            idx    = ID_W'(i);
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      own_mask = '0;
      for (int i = 0; i < N; i++)
         own_mask[i] = (state == GRANT) && (owner == ID_W'(i));
   end

   // In IDLE own_mask is zero, so the same search serves first grant and hand-over.
   assign others    = req & ~own_mask;
   assign owner_req = |(req & own_mask);
   assign at_limit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
   assign timeout   = at_limit && owner_req && (|others);
   assign {pick_found, pick_idx} = pick(others, ptr);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= '0;
         ptr       <= '0;
         hold_cnt  <= '0;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         ptr       <= ptr_nxt;
         hold_cnt  <= hold_cnt_nxt;
         gnt       <= gnt_nxt;
         gnt_valid <= (state_nxt == GRANT);
         gnt_id    <= gnt_id_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      ptr_nxt      = ptr;
      hold_cnt_nxt = hold_cnt;
      case (state)
         IDLE: begin
            hold_cnt_nxt = '0;
            if (pick_found) begin
               state_nxt = GRANT;
               owner_nxt = pick_idx;
               ptr_nxt   = (int'(pick_idx) == N - 1) ? '0 : pick_idx + ID_W'(1);
            end
         end
         GRANT: begin
            if (owner_req && !timeout) begin
               if (!at_limit && hold_cnt != CNT_MAX)
                  hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end else if (pick_found) begin
               owner_nxt    = pick_idx;
               ptr_nxt      = (int'(pick_idx) == N - 1) ? '0 : pick_idx + ID_W'(1);
               hold_cnt_nxt = '0;
            end else begin
               state_nxt    = IDLE;
               hold_cnt_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt_nxt    = '0;
      gnt_id_nxt = '0;
      if (state_nxt == GRANT) begin
         gnt_id_nxt = owner_nxt;
         for (int i = 0; i < N; i++)
            gnt_nxt[i] = (owner_nxt == ID_W'(i));
      end
   end

endmodule

// File: tb/tb_arbiter_rr_hold.sv
// tb/tb_arbiter_rr_hold.sv - scoreboard bench for arbiter_rr_hold at four parameter points
module tb_arbiter_rr_hold;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  req_a, req_b;
   logic [1:0]  req_c;
   logic [15:0] req_d;
   logic [4:0]  gnt_a, gnt_b;
   logic [1:0]  gnt_c;
   logic [15:0] gnt_d;
   logic        val_a, val_b, val_c, val_d;
   logic [2:0]  id_a, id_b;
   logic        id_c;
   logic [3:0]  id_d;

   always #5 clk = ~clk;

   arbiter_rr_hold #(.N(5), .ID_W(3), .MAX_HOLD(0), .CNT_W(8)) u_a (
      .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_valid(val_a), .gnt_id(id_a));
   arbiter_rr_hold #(.N(5), .ID_W(3), .MAX_HOLD(4), .CNT_W(8)) u_b (
      .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_valid(val_b), .gnt_id(id_b));
   arbiter_rr_hold #(.N(2), .ID_W(1), .MAX_HOLD(8), .CNT_W(8)) u_c (
      .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .gnt_valid(val_c), .gnt_id(id_c));
   arbiter_rr_hold #(.N(16), .ID_W(4), .MAX_HOLD(8), .CNT_W(8)) u_d (
      .clk(clk), .rst(rst), .req(req_d), .gnt(gnt_d), .gnt_valid(val_d), .gnt_id(id_d));

   typedef struct {
      int owner;
      int ptr;
      int cnt;
   } mdl_t;

   typedef struct {
      logic [15:0] g;
      int          id;
   } exp_t;

   mdl_t m[4];
   int   nn[4] = '{5, 5, 2, 16};
   int   mh[4] = '{0, 4, 8, 8};
   exp_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   wait_cnt[4][16];
   int   max_wait[4];
   logic track_wait = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int pick(input int n, input int p, input logic [15:0] r);
      for (int j = 0; j < n; j++) begin
         int k;
         k = (p + j) % n;
         if (((r >> k) & 16'h1) != 16'h0) return k;
      end
      return -1;
   endfunction

   function automatic mdl_t step(input mdl_t s, input int n, input int h,
                                 input logic [15:0] r, input logic rs);
      mdl_t        t;
      logic [15:0] oth;
      logic        own;
      int          k;
      t = s;
      if (rs) begin
         t.owner = -1; t.ptr = 0; t.cnt = 0;
         return t;
      end
      if (t.owner < 0) begin
         k = pick(n, t.ptr, r);
         if (k >= 0) begin
            t.owner = k;
            t.ptr   = (k + 1) % n;
         end
         t.cnt = 0;
         return t;
      end
      oth = r & ~(16'h1 << t.owner);
      own = ((r >> t.owner) & 16'h1) != 16'h0;
      if (own && !(h != 0 && t.cnt == h - 1 && oth != 0)) begin
         if (h == 0 ? t.cnt < 255 : t.cnt < h - 1) t.cnt++;
      end else if (oth != 0) begin
         k = pick(n, t.ptr, oth);
         t.owner = k;
         t.ptr   = (k + 1) % n;
         t.cnt   = 0;
      end else begin
         t.owner = -1;
         t.cnt   = 0;
      end
      return t;
   endfunction

   function automatic logic [15:0] next_req(input logic [15:0] cur, input logic [15:0] g, input int n);
      logic [15:0] nx;
      nx = '0;
      for (int i = 0; i < n; i++) begin
         logic [15:0] b;
         b = 16'h1 << i;
         if ((g & b) != 0) begin
            if ($urandom_range(7) != 0) nx |= b;
         end else if ((cur & b) != 0 || $urandom_range(3) == 0) begin
            nx |= b;
         end
      end
      return nx;
   endfunction

   task automatic tick(input logic rs, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [1:0] rc, input logic [15:0] rd);
      logic [15:0] r[4];
      logic [15:0] obs_g;
      int          obs_id;
      logic        obs_v;
      exp_t        e;
      rst = rs; req_a = ra; req_b = rb; req_c = rc; req_d = rd;
      r[0] = 16'(ra); r[1] = 16'(rb); r[2] = 16'(rc); r[3] = rd;
      for (int d = 0; d < 4; d++) begin
         m[d] = step(m[d], nn[d], mh[d], r[d], rs);
         e.g  = (m[d].owner < 0) ? 16'h0 : (16'h1 << m[d].owner);
         e.id = (m[d].owner < 0) ? 0 : m[d].owner;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
         case (d)
            0: begin obs_g = 16'(gnt_a); obs_id = int'(id_a); obs_v = val_a; end
            1: begin obs_g = 16'(gnt_b); obs_id = int'(id_b); obs_v = val_b; end
            2: begin obs_g = 16'(gnt_c); obs_id = int'(id_c); obs_v = val_c; end
            default: begin obs_g = gnt_d; obs_id = int'(id_d); obs_v = val_d; end
         endcase
         e = q.pop_front();
         check($sformatf("gnt_dut%0d", d), 32'(obs_g), 32'(e.g));
         check($sformatf("id_dut%0d", d), obs_id, e.id);
         check($sformatf("valid_dut%0d", d), 32'(obs_v), 32'(e.g != 0));
         if (track_wait) begin
            for (int i = 0; i < nn[d]; i++) begin
               if (((r[d] >> i) & 16'h1) != 0 && ((obs_g >> i) & 16'h1) == 0)
                  wait_cnt[d][i]++;
               else
                  wait_cnt[d][i] = 0;
               if (wait_cnt[d][i] > max_wait[d]) max_wait[d] = wait_cnt[d][i];
            end
         end
      end
   endtask

   initial begin
      logic [4:0]  ra, rb;
      logic [15:0] rc, rd;
      for (int d = 0; d < 4; d++) begin
         m[d].owner = -1; m[d].ptr = 0; m[d].cnt = 0; max_wait[d] = 0;
         for (int i = 0; i < 16; i++) wait_cnt[d][i] = 0;
      end
      rst = 1'b1; req_a = '0; req_b = '0; req_c = '0; req_d = '0;

      tick(1'b1, 5'b0, 5'b0, 2'b0, 16'h0);
      tick(1'b1, 5'b0, 5'b0, 2'b0, 16'h0);
      check("rst_ptr", 32'(u_a.ptr), 0);
      check("rst_hold_cnt", 32'(u_a.hold_cnt), 0);

      // Hold on DUT a with no timeout; 4-cycle alternation on DUT b.
      for (int c = 0; c < 24; c++) begin
         tick(1'b0, 5'b10110, 5'b00011, 2'b0, 16'h0);
         if (c == 0) begin
            check("first_id", 32'(id_a), 1);
            check("first_ptr", 32'(u_a.ptr), 2);
         end
         check("hold_gnt", 32'(gnt_a), 32'h02);
         check("timeout_gnt", 32'(gnt_b), ((c / 4) % 2 == 0) ? 32'h1 : 32'h2);
      end

      tick(1'b0, 5'b10100, 5'b00001, 2'b0, 16'h0);
      check("handover_gnt", 32'(gnt_a), 32'h04);
      check("lone_owner_gnt", 32'(gnt_b), 32'h01);
      tick(1'b0, 5'b00000, 5'b00001, 2'b0, 16'h0);
      check("release_gnt", 32'(gnt_a), 0);
      check("release_valid", 32'(val_a), 0);
      for (int c = 0; c < 8; c++) tick(1'b0, 5'b0, 5'b00001, 2'b0, 16'h0);
      check("timeout_sat_cnt", 32'(u_b.hold_cnt), 3);
      check("timeout_sat_gnt", 32'(gnt_b), 32'h01);

      for (int c = 0; c < 300; c++) tick(1'b0, 5'b00001, 5'b0, 2'b0, 16'h0);
      check("cnt_sat_255", 32'(u_a.hold_cnt), 255);

      // One-cycle packets: each owner drops its request right after being granted.
      tick(1'b1, 5'b0, 5'b0, 2'b0, 16'h0);
      for (int s = 0; s < 6; s++) begin
         tick(1'b0, 5'b11111 & ~gnt_a, 5'b0, 2'b0, 16'h0);
         check("rr_order", 32'(id_a), s % 5);
      end

      tick(1'b0, 5'b01000, 5'b0, 2'b0, 16'h0);
      check("pre_rst_gnt", 32'(gnt_a), 32'h08);
      tick(1'b1, 5'b11111, 5'b0, 2'b0, 16'h0);
      check("mid_rst_gnt", 32'(gnt_a), 0);
      tick(1'b0, 5'b11111, 5'b0, 2'b0, 16'h0);
      check("post_rst_gnt", 32'(gnt_a), 32'h01);

      tick(1'b1, 5'b0, 5'b0, 2'b0, 16'h0);
      track_wait = 1'b1;
      rc = '0; rd = '0;
      for (int c = 0; c < 10000; c++) begin
         ra = 5'($urandom);
         rb = 5'($urandom);
         rc = next_req(rc, 16'(gnt_c), 2);
         rd = next_req(rd, gnt_d, 16);
         tick(1'b0, ra, rb, rc[1:0], rd);
      end
      check("starve_n2", 32'(max_wait[2] > (2 - 1) * 8 + 2), 0);
      check("starve_n16", 32'(max_wait[3] > (16 - 1) * 8 + 16), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
